serial_pattern_tx: RTL

//  Serial pattern transmitter. Accepts a WIDTH-bit word through a one-cycle

---
 rtl/serial_pattern_tx.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: loads a WIDTH-bit word on start&&ready and shifts it
// out MSB-first with sof/eof markers, a done/aborted pulse and an inter-frame gap.
module serial_pattern_tx #(
  parameter int WIDTH = 6,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic             abort,
  output logic             ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sof,
  output logic             eof,
  output logic             done,
  output logic             aborted,
  output logic [1:0]       state
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10,
    S_GAP   = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic             ready_q, ready_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             sof_q, sof_d;
  logic             eof_q, eof_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;

  // Every output is computed for the *next* state so that it can be registered.
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    gap_cnt_d = gap_cnt_q;
    sout_d    = 1'b0;
    sof_d     = 1'b0;
    eof_d     = 1'b0;
    done_d    = 1'b0;
    aborted_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_SHIFT;
          shift_d = data;
          cnt_d   = '0;
          sout_d  = data[WIDTH-1];
          sof_d   = 1'b1;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          state_d   = S_IDLE;
          shift_d   = '0;
          cnt_d     = '0;
          aborted_d = 1'b1;
        end else if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
          shift_d = '0;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          shift_d = shift_q << 1;
          cnt_d   = cnt_q + 1'b1;
          sout_d  = shift_q[WIDTH-2];
          eof_d   = (cnt_q == CW'(WIDTH - 2));
        end
      end
      S_DONE: begin
        gap_cnt_d = '0;
        state_d   = (GAP == 0) ? S_IDLE : S_GAP;
      end
      S_GAP: begin
        if (gap_cnt_q == GW'(GAP - 1)) begin
          state_d   = S_IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    ready_d      = (state_d == S_IDLE);
    sout_valid_d = (state_d == S_SHIFT);
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use <= so every flop samples pre-edge values.
    if (rst) begin
      state_q      <= S_IDLE;
      shift_q      <= '0;
      cnt_q        <= '0;
      gap_cnt_q    <= '0;
      ready_q      <= 1'b1;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      sof_q        <= 1'b0;
      eof_q        <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      ready_q      <= ready_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      sof_q        <= sof_d;
      eof_q        <= eof_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
    end
  end

  assign ready      = ready_q;
  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign sof        = sof_q;
  assign eof        = eof_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign state      = state_q;

endmodule
